l2_req_arbiter: RTL and testbench

Two-source request arbiter and response router in front of `l2_cache_1m_8w`. It buffers one request each from the L1 instruction cache (IC) and the L1 data cache (DC) and grants them round-robin into a registered L2 request port. For each accepted read, it tracks the source through a fixed-latency pipeline so the L2 read data returns to the requester. It is the single upstream client of the L2.

---
 rtl/l2_arb_pkg.sv | 29 ++
 rtl/l2_arb_slot.sv | 48 ++++
 rtl/l2_req_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_l2_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 request arbiter: source ids, the buffered request
// record and the response-routing tag.
package l2_arb_pkg;

  localparam int unsigned L2_ADDR_W = 64;
  localparam int unsigned L2_DATA_W = 64;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } l2_src_e;

  typedef struct packed {
    logic [L2_ADDR_W-1:0] addr;
    logic                 write;
    logic [L2_DATA_W-1:0] wdata;
    l2_src_e              src;
  } l2_req_t;

  typedef struct packed {
    logic    valid;
    l2_src_e src;
  } l2_tag_t;

  function automatic l2_src_e other_src(input l2_src_e s);
    return (s == SRC_IC) ? SRC_DC : SRC_IC;
  endfunction

endpackage

// File: rtl/l2_arb_slot.sv
// One-entry request buffer. Ready is its own flop so the upstream handshake
// never depends combinationally on the downstream grant.
module l2_arb_slot
  import l2_arb_pkg::*;
#(
  parameter type req_t = l2_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_valid,
  input  req_t load_data,
  input  logic take,
  output logic ready,
  output logic full,
  output req_t data
);

  logic full_r;
  logic ready_r;
  req_t data_r;
  logic load_s;

  assign load_s = load_valid && ready_r;

  // Slot occupancy and payload; a load and a take can never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 1'b0;
      ready_r <= 1'b1;
      data_r  <= '0;
    end else if (load_s) begin
      full_r  <= 1'b1;
      ready_r <= 1'b0;
      data_r  <= load_data;
    end else if (take) begin
      full_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      full_r  <= full_r;
      ready_r <= ready_r;
    end
  end

  assign ready = ready_r;
  assign full  = full_r;
  assign data  = data_r;

endmodule

// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter between the L1 I-cache and D-cache in front of the L2,
// with a fixed-latency tag pipeline that routes read data back to its source.
module l2_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_req_ready_o,
  output logic              ic_resp_valid_o,
  output logic [DATA_W-1:0] ic_resp_rdata_o,
  input  logic              dc_req_valid_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic              dc_req_write_i,
  input  logic [DATA_W-1:0] dc_req_wdata_i,
  output logic              dc_req_ready_o,
  output logic              dc_resp_valid_o,
  output logic [DATA_W-1:0] dc_resp_rdata_o,
  output logic              l2_req_valid_o,
  output logic [ADDR_W-1:0] l2_req_addr_o,
  output logic              l2_req_write_o,
  output logic [DATA_W-1:0] l2_req_wdata_o,
  input  logic              l2_req_ready_i,
  input  logic [DATA_W-1:0] l2_resp_rdata_i
);

  l2_req_t     ic_in_s, dc_in_s, ic_slot_s, dc_slot_s, sel_req_s;
  logic        ic_full_s, dc_full_s;
  logic        load_out_s, grant_ic_s, grant_dc_s, grant_any_s, hs_s;
  l2_req_t     out_r;
  logic        out_valid_r;
  l2_src_e     rr_ptr_r;
  l2_tag_t     tag_pipe_r [RESP_LAT];
  l2_tag_t     tag_in_s;
  logic              ic_resp_valid_r, dc_resp_valid_r;
  logic [DATA_W-1:0] ic_resp_rdata_r, dc_resp_rdata_r;

  // Assemble slot payloads; I-cache traffic is read-only.
  always_comb begin
    ic_in_s       = '0;
    ic_in_s.addr  = L2_ADDR_W'(ic_req_addr_i);
    ic_in_s.write = 1'b0;
    ic_in_s.wdata = {L2_DATA_W{1'b0}};
    ic_in_s.src   = SRC_IC;
    dc_in_s       = '0;
    dc_in_s.addr  = L2_ADDR_W'(dc_req_addr_i);
    dc_in_s.write = dc_req_write_i;
    dc_in_s.wdata = L2_DATA_W'(dc_req_wdata_i);
    dc_in_s.src   = SRC_DC;
  end

  l2_arb_slot #(.req_t(l2_req_t)) u_ic_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (ic_req_valid_i),
    .load_data  (ic_in_s),
    .take       (grant_ic_s),
    .ready      (ic_req_ready_o),
    .full       (ic_full_s),
    .data       (ic_slot_s)
  );

  l2_arb_slot #(.req_t(l2_req_t)) u_dc_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (dc_req_valid_i),
    .load_data  (dc_in_s),
    .take       (grant_dc_s),
    .ready      (dc_req_ready_o),
    .full       (dc_full_s),
    .data       (dc_slot_s)
  );

  assign load_out_s  = !out_valid_r || l2_req_ready_i;
  assign hs_s        = out_valid_r && l2_req_ready_i;
  assign grant_any_s = grant_ic_s || grant_dc_s;

  // Grant selection: a lone full slot wins, a tie goes to the pointer.
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (load_out_s) begin
      if (ic_full_s && dc_full_s) begin
        grant_ic_s = (rr_ptr_r == SRC_IC);
        grant_dc_s = (rr_ptr_r == SRC_DC);
      end else begin
        grant_ic_s = ic_full_s;
        grant_dc_s = dc_full_s;
      end
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  assign sel_req_s = grant_dc_s ? dc_slot_s : ic_slot_s;

  // Output request register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
      rr_ptr_r    <= SRC_IC;
    end else begin
      if (load_out_s) begin
        out_valid_r <= grant_any_s;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (grant_any_s) begin
        out_r    <= sel_req_s;
        rr_ptr_r <= other_src(sel_req_s.src);
      end else begin
        out_r    <= out_r;
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign l2_req_valid_o = out_valid_r;
  assign l2_req_addr_o  = ADDR_W'(out_r.addr);
  assign l2_req_write_o = out_r.write;
  assign l2_req_wdata_o = DATA_W'(out_r.wdata);

  assign tag_in_s.valid = hs_s && !out_r.write;
  assign tag_in_s.src   = out_r.src;

  // Tag shift pipeline; its head lines up with the L2 read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_LAT; i++) begin
        tag_pipe_r[i] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= tag_in_s;
      for (int i = 1; i < RESP_LAT; i++) begin
        tag_pipe_r[i] <= tag_pipe_r[i-1];
      end
    end
  end

  // Response demux: capture read data into the requester's register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_resp_valid_r <= 1'b0;
      dc_resp_valid_r <= 1'b0;
      ic_resp_rdata_r <= {DATA_W{1'b0}};
      dc_resp_rdata_r <= {DATA_W{1'b0}};
    end else if (tag_pipe_r[RESP_LAT-1].valid) begin
      case (tag_pipe_r[RESP_LAT-1].src)
        SRC_IC: begin
          ic_resp_valid_r <= 1'b1;
          dc_resp_valid_r <= 1'b0;
          ic_resp_rdata_r <= l2_resp_rdata_i;
        end
        SRC_DC: begin
          ic_resp_valid_r <= 1'b0;
          dc_resp_valid_r <= 1'b1;
          dc_resp_rdata_r <= l2_resp_rdata_i;
        end
        default: begin
          ic_resp_valid_r <= 1'b0;
          dc_resp_valid_r <= 1'b0;
        end
      endcase
    end else begin
      ic_resp_valid_r <= 1'b0;
      dc_resp_valid_r <= 1'b0;
    end
  end

  assign ic_resp_valid_o = ic_resp_valid_r;
  assign dc_resp_valid_o = dc_resp_valid_r;
  assign ic_resp_rdata_o = ic_resp_rdata_r;
  assign dc_resp_rdata_o = dc_resp_rdata_r;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter with a small fixed-latency L2 read model.
module tb_l2_req_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          ic_req_valid_i;
  logic [AW-1:0] ic_req_addr_i;
  logic          ic_req_ready_o;
  logic          ic_resp_valid_o;
  logic [DW-1:0] ic_resp_rdata_o;
  logic          dc_req_valid_i;
  logic [AW-1:0] dc_req_addr_i;
  logic          dc_req_write_i;
  logic [DW-1:0] dc_req_wdata_i;
  logic          dc_req_ready_o;
  logic          dc_resp_valid_o;
  logic [DW-1:0] dc_resp_rdata_o;
  logic          l2_req_valid_o;
  logic [AW-1:0] l2_req_addr_o;
  logic          l2_req_write_o;
  logic [DW-1:0] l2_req_wdata_o;
  logic          l2_req_ready_i;
  logic [DW-1:0] l2_resp_rdata_i;

  logic [DW-1:0] lat_q [LAT];

  int total;
  int bad;

  l2_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RESP_LAT(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_req_valid_i  (ic_req_valid_i),
    .ic_req_addr_i   (ic_req_addr_i),
    .ic_req_ready_o  (ic_req_ready_o),
    .ic_resp_valid_o (ic_resp_valid_o),
    .ic_resp_rdata_o (ic_resp_rdata_o),
    .dc_req_valid_i  (dc_req_valid_i),
    .dc_req_addr_i   (dc_req_addr_i),
    .dc_req_write_i  (dc_req_write_i),
    .dc_req_wdata_i  (dc_req_wdata_i),
    .dc_req_ready_o  (dc_req_ready_o),
    .dc_resp_valid_o (dc_resp_valid_o),
    .dc_resp_rdata_o (dc_resp_rdata_o),
    .l2_req_valid_o  (l2_req_valid_o),
    .l2_req_addr_o   (l2_req_addr_o),
    .l2_req_write_o  (l2_req_write_o),
    .l2_req_wdata_o  (l2_req_wdata_o),
    .l2_req_ready_i  (l2_req_ready_i),
    .l2_resp_rdata_i (l2_resp_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L2 read data is a fixed function of the address so 0x1000 returns 0xDEADBEEF.
  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return 64'h0000_0000_DEAD_BEEF ^ (a ^ 64'h0000_0000_0000_1000);
  endfunction

  // L2 model: read data appears LAT edges after the handshake edge.
  always @(posedge clk) begin
    if (l2_req_valid_o && l2_req_ready_i && !l2_req_write_o) begin
      lat_q[0] <= rd_val(l2_req_addr_o);
    end else begin
      lat_q[0] <= 64'h0;
    end
    for (int i = 1; i < LAT; i++) begin
      lat_q[i] <= lat_q[i-1];
    end
  end
  assign l2_resp_rdata_i = lat_q[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ic_req_valid_i = 1'b0;
    ic_req_addr_i  = 64'h0;
    dc_req_valid_i = 1'b0;
    dc_req_addr_i  = 64'h0;
    dc_req_write_i = 1'b0;
    dc_req_wdata_i = 64'h0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    idle_inputs();
    l2_req_ready_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int n_ic, n_dc, n_gr, alt_bad;
  logic last_src, cur_src;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < LAT; i++) lat_q[i] = 64'h0;

    // Reset values and idle behaviour
    rst_n = 1'b0;
    idle_inputs();
    l2_req_ready_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_ic_ready", 64'(ic_req_ready_o), 64'h1);
    check("rst_dc_ready", 64'(dc_req_ready_o), 64'h1);
    check("rst_l2_addr", l2_req_addr_o, 64'h0);
    check("rst_l2_wdata", l2_req_wdata_o, 64'h0);
    check("rst_l2_write", 64'(l2_req_write_o), 64'h0);
    check("rst_rdata", ic_resp_rdata_o | dc_resp_rdata_o, 64'h0);
    for (int k = 0; k < 5; k++) begin
      check("idle_valids", 64'({ic_resp_valid_o, dc_resp_valid_o, l2_req_valid_o}), 64'h0);
      check("idle_ready", 64'({ic_req_ready_o, dc_req_ready_o}), 64'h3);
      tick();
    end

    // Single IC read
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = 64'h1000;
    tick();
    ic_req_valid_i = 1'b0;
    check("sr_ic_busy", 64'(ic_req_ready_o), 64'h0);
    check("sr_not_yet", 64'(l2_req_valid_o), 64'h0);
    tick();
    check("sr_l2_valid", 64'(l2_req_valid_o), 64'h1);
    check("sr_l2_addr", l2_req_addr_o, 64'h1000);
    check("sr_l2_write", 64'(l2_req_write_o), 64'h0);
    tick();
    check("sr_l2_done", 64'(l2_req_valid_o), 64'h0);
    check("sr_ic_ready", 64'(ic_req_ready_o), 64'h1);
    check("sr_no_resp_yet", 64'(ic_resp_valid_o), 64'h0);
    tick();
    check("sr_no_resp_yet2", 64'(ic_resp_valid_o), 64'h0);
    tick();
    check("sr_ic_resp", 64'(ic_resp_valid_o), 64'h1);
    check("sr_ic_rdata", ic_resp_rdata_o, 64'hDEAD_BEEF);
    check("sr_dc_quiet", 64'(dc_resp_valid_o), 64'h0);
    tick();
    check("sr_pulse_end", 64'(ic_resp_valid_o), 64'h0);
    check("sr_rdata_hold", ic_resp_rdata_o, 64'hDEAD_BEEF);

    // Simultaneous IC and DC reads
    apply_reset();
    check("sim_rdata_cleared", ic_resp_rdata_o, 64'h0);
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = 64'h100;
    dc_req_valid_i = 1'b1;
    dc_req_addr_i  = 64'h200;
    tick();
    idle_inputs();
    tick();
    check("sim_first_addr", l2_req_addr_o, 64'h100);
    check("sim_first_valid", 64'(l2_req_valid_o), 64'h1);
    tick();
    check("sim_second_addr", l2_req_addr_o, 64'h200);
    check("sim_second_valid", 64'(l2_req_valid_o), 64'h1);
    tick();
    check("sim_drained", 64'(l2_req_valid_o), 64'h0);
    tick();
    check("sim_ic_resp", 64'({ic_resp_valid_o, dc_resp_valid_o}), 64'h2);
    check("sim_ic_rdata", ic_resp_rdata_o, 64'hDEAD_AFEF);
    tick();
    check("sim_dc_resp", 64'({ic_resp_valid_o, dc_resp_valid_o}), 64'h1);
    check("sim_dc_rdata", dc_resp_rdata_o, 64'hDEAD_ACEF);

    // Backpressure with a DC write followed by a DC read
    apply_reset();
    l2_req_ready_i = 1'b0;
    dc_req_valid_i = 1'b1;
    dc_req_addr_i  = 64'h40;
    dc_req_write_i = 1'b1;
    dc_req_wdata_i = 64'h55;
    tick();
    check("bp_dc_full", 64'(dc_req_ready_o), 64'h0);
    dc_req_addr_i  = 64'h48;
    dc_req_write_i = 1'b0;
    dc_req_wdata_i = 64'h0;
    tick();
    check("bp_issue_addr", l2_req_addr_o, 64'h40);
    check("bp_issue_ctl", 64'({l2_req_valid_o, l2_req_write_o}), 64'h3);
    check("bp_issue_wdata", l2_req_wdata_o, 64'h55);
    tick();
    dc_req_valid_i = 1'b0;
    check("bp_dc_accept", 64'(dc_req_ready_o), 64'h0);
    for (int k = 0; k < 5; k++) begin
      check("bp_stable_addr", l2_req_addr_o, 64'h40);
      check("bp_stable_ctl", 64'({l2_req_valid_o, l2_req_write_o, l2_req_wdata_o[7:0]}), 64'h355);
      tick();
    end
    l2_req_ready_i = 1'b1;
    tick();
    check("bp_next_addr", l2_req_addr_o, 64'h48);
    check("bp_next_ctl", 64'({l2_req_valid_o, l2_req_write_o}), 64'h2);
    tick();
    check("bp_drained", 64'(l2_req_valid_o), 64'h0);
    tick();
    check("bp_no_wr_resp", 64'(dc_resp_valid_o), 64'h0);
    tick();
    check("bp_rd_resp", 64'({ic_resp_valid_o, dc_resp_valid_o}), 64'h1);
    check("bp_rd_rdata", dc_resp_rdata_o, 64'hDEAD_AEA7);
    tick();
    check("bp_rd_pulse_end", 64'(dc_resp_valid_o), 64'h0);

    // Fairness under continuous requests from both sources
    apply_reset();
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = 64'h2000;
    dc_req_valid_i = 1'b1;
    dc_req_addr_i  = 64'h3000;
    n_ic = 0; n_dc = 0; n_gr = 0; alt_bad = 0; last_src = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (l2_req_valid_o && l2_req_ready_i) begin
        cur_src = (l2_req_addr_o == 64'h3000);
        if (n_gr > 0 && cur_src == last_src) alt_bad++;
        if (cur_src) n_dc++;
        else n_ic++;
        n_gr++;
        last_src = cur_src;
      end
    end
    idle_inputs();
    check("fair_alternate", 64'(alt_bad), 64'h0);
    check("fair_total", 64'(n_gr), 64'd19);
    check("fair_ic_range", 64'(n_ic >= 9 && n_ic <= 11), 64'h1);
    check("fair_dc_range", 64'(n_dc >= 9 && n_dc <= 11), 64'h1);
    repeat (8) tick();

    // Reset one cycle after an IC read handshake
    apply_reset();
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = 64'h1000;
    tick();
    ic_req_valid_i = 1'b0;
    tick();
    check("mf_issued", 64'(l2_req_valid_o), 64'h1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("mf_no_resp", 64'({ic_resp_valid_o, dc_resp_valid_o}), 64'h0);
      check("mf_ready", 64'({ic_req_ready_o, dc_req_ready_o}), 64'h3);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
